// File: rtl/mem_access_unit.sv
// Load/store front end for a single-port synchronous IP_RAM (word addressed,
// no byte enables). Sub-word stores are done as read-modify-write.
// Optional feature macro: MAU_PERF_CNT_EN adds saturating load/store/error
// response counters (perf_rd_cnt, perf_wr_cnt, perf_err_cnt).
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef MAU_PERF_CNT_EN
  ,
  output logic [15:0]           perf_rd_cnt,
  output logic [15:0]           perf_wr_cnt,
  output logic [15:0]           perf_err_cnt
`endif
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    lat_we, lat_we_nxt;
  logic                    lat_signed, lat_signed_nxt;
  logic [1:0]              lat_size, lat_size_nxt;
  logic [1:0]              lat_lane, lat_lane_nxt;
  logic [31:0]             lat_wdata, lat_wdata_nxt;
  logic                    req_ready_nxt, rsp_valid_nxt, rsp_err_nxt, ram_wren_nxt;
  logic [31:0]             rsp_rdata_nxt;
  logic [ADDR_WIDTH-1:0]   ram_address_nxt;
  logic [DATA_WIDTH-1:0]   ram_data_nxt;
  logic                    req_err_c;

  // Shift the addressed byte/half down to bit 0 and extend; words pass through.
  function automatic logic [31:0] load_fmt(input logic [31:0] q, input logic [1:0] size,
                                           input logic [1:0] lane, input logic sgn);
    logic [31:0] sh;
    sh = q >> {lane, 3'b000};
    case (size)
      2'b00:   load_fmt = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   load_fmt = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_fmt = q;
    endcase
  endfunction

  // Overlay store data on the addressed lane(s), keeping the other bytes.
  function automatic logic [31:0] store_merge(input logic [31:0] q, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = q;
    if (size == 2'b00) r[{lane, 3'b000} +: 8] = wd[7:0];
    else               r[{lane[1], 4'b0000} +: 16] = wd[15:0];
    return r;
  endfunction

  // Request legality: size, alignment and address range.
  always_comb begin
    req_err_c = (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
             || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    lat_we_nxt      = lat_we;
    lat_signed_nxt  = lat_signed;
    lat_size_nxt    = lat_size;
    lat_lane_nxt    = lat_lane;
    lat_wdata_nxt   = lat_wdata;
    req_ready_nxt   = req_ready;
    rsp_valid_nxt   = rsp_valid;
    rsp_err_nxt     = rsp_err;
    rsp_rdata_nxt   = rsp_rdata;
    ram_wren_nxt    = 1'b0;
    ram_address_nxt = ram_address;
    ram_data_nxt    = ram_data;
    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_nxt  = 1'b0;
          lat_we_nxt     = req_we;
          lat_signed_nxt = req_signed;
          lat_size_nxt   = req_size;
          lat_lane_nxt   = req_addr[1:0];
          lat_wdata_nxt  = req_wdata;
          cnt_nxt        = '0;
          if (req_err_c) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
            state_nxt     = RESP;
          end else begin
            ram_address_nxt = req_addr[ADDR_WIDTH+1:2];
            if (req_we && req_size == 2'b10) begin
              ram_wren_nxt = 1'b1;
              ram_data_nxt = req_wdata;
              state_nxt    = WR;
            end else begin
              state_nxt = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt == CNT_W'(RD_LAT)) begin
          if (lat_we) begin
            ram_wren_nxt = 1'b1;
            ram_data_nxt = store_merge(ram_q, lat_wdata, lat_size, lat_lane);
            state_nxt    = WR;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b0;
            rsp_rdata_nxt = load_fmt(ram_q, lat_size, lat_lane, lat_signed);
            state_nxt     = RESP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WR: begin
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;
        state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = '0;
          req_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_we      <= 1'b0;
      lat_signed  <= 1'b0;
      lat_size    <= 2'b00;
      lat_lane    <= 2'b00;
      lat_wdata   <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lat_we      <= lat_we_nxt;
      lat_signed  <= lat_signed_nxt;
      lat_size    <= lat_size_nxt;
      lat_lane    <= lat_lane_nxt;
      lat_wdata   <= lat_wdata_nxt;
      req_ready   <= req_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      ram_wren    <= ram_wren_nxt;
      ram_address <= ram_address_nxt;
      ram_data    <= ram_data_nxt;
    end
  end

`ifdef MAU_PERF_CNT_EN
  // Saturating per-class counters, bumped on the response handshake.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else if (state == RESP && rsp_ready) begin
      if (rsp_err) begin
        if (perf_err_cnt != 16'hFFFF) perf_err_cnt <= perf_err_cnt + 16'd1;
      end else if (lat_we) begin
        if (perf_wr_cnt != 16'hFFFF) perf_wr_cnt <= perf_wr_cnt + 16'd1;
      end else begin
        if (perf_rd_cnt != 16'hFFFF) perf_rd_cnt <= perf_rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural IP_RAM (1-cycle read)
// and a response scoreboard queue.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q = '0;
`ifdef MAU_PERF_CNT_EN
  logic [15:0] perf_rd_cnt, perf_wr_cnt, perf_err_cnt;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_rd = 0, m_wr = 0, m_err = 0;
  logic [31:0] mem [0:65535];

  mem_access_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RD_LAT(1)) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
`ifdef MAU_PERF_CNT_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_err_cnt(perf_err_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Single-port synchronous RAM, one-cycle read latency, read-before-write.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: drive, track write strobes, then check response timing/contents.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_rsp_cyc, input int exp_wr_cyc,
                         input logic [15:0] exp_waddr, input logic [31:0] exp_wdata,
                         input int hold);
    int          rsp_cyc;
    int          wr_n;
    int          wr_cyc;
    logic [15:0] wa;
    logic [31:0] wd;
    logic        got;
    exp_t        e;
    got = 1'b0; wr_n = 0; wr_cyc = 0; rsp_cyc = 0; wa = '0; wd = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready) break;
    end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (ram_wren) begin
        wr_n++; wr_cyc = c; wa = ram_address; wd = ram_data;
      end
      if (rsp_valid) begin
        got = 1'b1; rsp_cyc = c; break;
      end
    end
    check({tag, " rsp_valid"}, 32'(got), 32'd1);
    e = exp_q.pop_front();
    check({tag, " rsp_cycle"}, 32'(rsp_cyc), 32'(exp_rsp_cyc));
    check({tag, " rsp_rdata"}, rsp_rdata, e.rdata);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(e.err));
    check({tag, " wren_count"}, 32'(wr_n), (exp_wr_cyc != 0) ? 32'd1 : 32'd0);
    if (exp_wr_cyc != 0) begin
      check({tag, " wren_cycle"}, 32'(wr_cyc), 32'(exp_wr_cyc));
      check({tag, " ram_address"}, 32'(wa), 32'(exp_waddr));
      check({tag, " ram_data"}, wd, exp_wdata);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rsp_rdata"}, rsp_rdata, e.rdata);
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " hold ram_wren"}, 32'(ram_wren), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    check({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post req_ready"}, 32'(req_ready), 32'd1);
    if (exp_err) m_err++;
    else if (we) m_wr++;
    else m_rd++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, " ram_wren"}, 32'(ram_wren), 32'd0);
    check({tag, " ram_address"}, 32'(ram_address), 32'd0);
    check({tag, " ram_data"}, ram_data, 32'd0);
`ifdef MAU_PERF_CNT_EN
    check({tag, " perf_rd"}, 32'(perf_rd_cnt), 32'd0);
    check({tag, " perf_wr"}, 32'(perf_wr_cnt), 32'd0);
    check({tag, " perf_err"}, 32'(perf_err_cnt), 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;

    // Reset held over a few edges.
    repeat (2) @(posedge clock);
    #1 check_reset_values("reset");
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock);
    #1 check("reset release req_ready", 32'(req_ready), 32'd1);

    // Word store / load and sub-word read-modify-write.
    run_req("st_w 0x8",   1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 16'h0002, 32'hDEAD_BEEF, 0);
    run_req("ld_w 0x8",   1'b0, 2'b10, 1'b1, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 16'h0, 32'h0, 0);
    run_req("st_b 0x9",   1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'hAAAA_AA55, 32'h0, 1'b0, 4, 3, 16'h0002, 32'hDEAD_55EF, 0);
    run_req("ld_bs 0xB",  1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0,         32'hFFFF_FFDE, 1'b0, 3, 0, 16'h0, 32'h0, 0);
    run_req("ld_hu 0xA",  1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0,         32'h0000_DEAD, 1'b0, 3, 0, 16'h0, 32'h0, 0);
    run_req("ld_hs 0x8",  1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0,         32'h0000_55EF, 1'b0, 3, 0, 16'h0, 32'h0, 0);
    run_req("ld_bu 0x9",  1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0,         32'h0000_0055, 1'b0, 3, 0, 16'h0, 32'h0, 0);
    run_req("st_h 0xA",   1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h1234_ABCD, 32'h0, 1'b0, 4, 3, 16'h0002, 32'hABCD_55EF, 0);
    run_req("ld_w2 0x8",  1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         32'hABCD_55EF, 1'b0, 3, 0, 16'h0, 32'h0, 0);
    run_req("ld_hs 0xA",  1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0,         32'hFFFF_ABCD, 1'b0, 3, 0, 16'h0, 32'h0, 0);

    // Error requests: no RAM write, response in cycle 1.
    run_req("err half",   1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,         32'h0, 1'b1, 1, 0, 16'h0, 32'h0, 0);
    run_req("err word",   1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h1111_2222, 32'h0, 1'b1, 1, 0, 16'h0, 32'h0, 0);
    run_req("err size",   1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h3333_4444, 32'h0, 1'b1, 1, 0, 16'h0, 32'h0, 0);
    run_req("err range",  1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'h0,         32'h0, 1'b1, 1, 0, 16'h0, 32'h0, 0);

    // Response backpressure, then an immediate back-to-back request.
    run_req("bp ld 0x8",  1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         32'hABCD_55EF, 1'b0, 3, 0, 16'h0, 32'h0, 5);
    run_req("b2b ld 0xC", 1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,         32'h0, 1'b0, 3, 0, 16'h0, 32'h0, 0);

`ifdef MAU_PERF_CNT_EN
    check("perf_rd", 32'(perf_rd_cnt), 32'(m_rd));
    check("perf_wr", 32'(perf_wr_cnt), 32'(m_wr));
    check("perf_err", 32'(perf_err_cnt), 32'(m_err));
`endif

    // Reset asserted while the word store is in WR.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr  = 32'h0000_0010; req_wdata = 32'h1234_5678;
    @(posedge clock);
    #1 req_valid = 1'b0;
    check("mid-WR ram_wren", 32'(ram_wren), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("mid-WR reset");
    @(negedge clock);
    @(negedge clock) rst_n = 1'b1;

    run_req("post-rst ld 0x8",  1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'hABCD_55EF, 1'b0, 3, 0, 16'h0, 32'h0, 0);
    run_req("post-rst ld 0x10", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h0,         1'b0, 3, 0, 16'h0, 32'h0, 0);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
